// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder/subtractor.
//   DEFAULT_WIDTH : default operand/result width in bits
//   state_t       : control FSM state encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// One-bit full adder used as the serial datapath bit.
//   x, y  : operand bits
//   cin   : carry in
//   sum   : x ^ y ^ cin
//   cout  : majority(x, y, cin)
// -----------------------------------------------------------------------------
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder/subtractor, one bit per clock, LSB first.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : begin an operation (accepted only in IDLE)
//   sub    : 0 = a + b + cin, 1 = a - b
//   a, b   : operands
//   cin    : carry in (add mode only)
//   busy   : high for the WIDTH cycles the bits are being processed
//   done   : one-cycle pulse, sum/cout/ovf valid from this cycle on
//   sum    : registered result, modulo 2^WIDTH
//   cout   : carry out of the MSB (subtract: 1 = no borrow)
//   ovf    : two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    // Operand shift registers; subtract mode is folded in at load time by
    // storing ~b and forcing the initial carry to 1, so no mode bit is kept.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Result bits collected so far; the final bit arrives straight from the
    // cell on the last RUN cycle, so only WIDTH-1 bits need storing.
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;

    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry_out;

    full_adder_cell u_fa (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_sum_bit),
        .cout (w_carry_out)
    );

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next_state = ST_RUN;
            ST_RUN:  if (w_last) w_next_state = ST_DONE;
            ST_DONE:             w_next_state = ST_IDLE;
            default:             w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == ST_RUN);
        done     = (r_state == ST_DONE);
        // start is only looked at in IDLE, so it cannot disturb RUN or DONE.
        w_accept = (r_state == ST_IDLE) && start;
        w_last   = (r_state == ST_RUN) && (r_cnt == LAST_BIT);
    end

    // ---------------------------------------------------------- datapath
    assign w_acc_next = {w_sum_bit, r_acc};

    // Control-visible state: cleared by reset so an aborted run leaves
    // all outputs at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_carry <= sub ? 1'b1 : cin;
        end else if (busy) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_carry_out;
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_carry_out;
                // r_carry still holds the carry into the MSB here.
                r_ovf  <= r_carry ^ w_carry_out;
            end
        end
    end

    // NOTE: the shift registers carry no reset; they are always reloaded on
    // accept before being read, so resetting them would only add cost.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= sub ? ~b : b;
        end else if (busy) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_acc <= w_acc_next[WIDTH-1:1];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder (WIDTH = 8). Expected results come from an
// arithmetic model, are queued when an operation is launched and compared
// when done is seen. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic; overflow from operand/result sign bits.
    function automatic res_t model(input logic s, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic c);
        logic [W-1:0] yy;
        logic [W:0]   full;
        logic [W:0]   cc;
        res_t         r;
        yy     = s ? ~y : y;
        cc     = '0;
        cc[0]  = s ? 1'b1 : c;
        full   = {1'b0, x} + {1'b0, yy} + cc;
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (r.sum[W-1] != x[W-1]);
        return r;
    endfunction

    // Called at a falling edge. exp_lat counts rising edges from the edge
    // where start is first sampled to the cycle in which done is seen.
    task automatic run_op(input string tag, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic c, input int exp_lat,
                          input bit disturb, input bit chain);
        int   n;
        int   busy_cnt;
        bit   seen;
        res_t e;
        exp_q.push_back(model(s, x, y, c));
        start = 1'b1; sub = s; a = x; b = y; cin = c;
        n = 0; busy_cnt = 0; seen = 1'b0;
        while (n < 4 * W && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busy) busy_cnt++;
            if (busy && busy_cnt == 1) begin
                // Scramble every input once accepted; must have no effect.
                start = 1'b0; a = ~x; b = ~y; sub = ~s; cin = ~c;
            end
            if (disturb && busy && busy_cnt == 3) begin
                start = 1'b1; a = 8'h5A; b = 8'hC3; sub = 1'b1; cin = 1'b1;
            end
            if (disturb && busy && busy_cnt == 5) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_latency"}, 64'(n), 64'(exp_lat));
            check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
            check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_sum"}, 64'(sum), 64'(e.sum));
                check({tag, "_cout"}, 64'(cout), 64'(e.cout));
                check({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
            end
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
        if (!chain) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_done_pulse_one_cycle"}, 64'(done), 64'd0);
            check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int cnt;
        int guard;

        // Reset with start held high: reset must win.
        rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 8'd9; b = 8'd9; cin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        run_op("add_3_5",      1'b0, 8'd3,   8'd5, 1'b0, W + 1, 1'b0, 1'b0);
        run_op("add_255_0_c1", 1'b0, 8'd255, 8'd0, 1'b1, W + 1, 1'b0, 1'b0);
        run_op("add_127_1",    1'b0, 8'd127, 8'd1, 1'b0, W + 1, 1'b0, 1'b0);
        run_op("sub_5_7",      1'b1, 8'd5,   8'd7, 1'b0, W + 1, 1'b0, 1'b0);
        run_op("sub_7_5_cin1", 1'b1, 8'd7,   8'd5, 1'b1, W + 1, 1'b0, 1'b0);
        run_op("sub_m128_1",   1'b1, 8'h80,  8'd1, 1'b0, W + 1, 1'b0, 1'b0);

        // start pulsed with new operands mid-RUN: ignored, no second done.
        run_op("disturb", 1'b0, 8'd100, 8'd27, 1'b1, W + 1, 1'b1, 1'b0);
        cnt = 0;
        repeat (2 * W) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt++;
        end
        check("disturb_no_extra_done", 64'(cnt), 64'd0);

        // Back-to-back: start held from the done cycle is taken on the first
        // IDLE edge, giving an accept-to-accept spacing of W+2.
        run_op("b2b_first",  1'b0, 8'd200, 8'd100, 1'b0, W + 1, 1'b0, 1'b1);
        run_op("b2b_second", 1'b1, 8'd10,  8'd20,  1'b0, W + 2, 1'b0, 1'b0);

        // Reset during RUN cycle 4: abort, outputs cleared, no done.
        start = 1'b1; sub = 1'b0; a = 8'hF0; b = 8'h0F; cin = 1'b1;
        cnt = 0; guard = 0;
        while (cnt < 4 && guard < 4 * W) begin
            @(posedge clk);
            guard++;
            @(negedge clk);
            if (busy) begin
                cnt++;
                start = 1'b0;
            end
        end
        check("midrun_reached_cycle4", 64'(cnt), 64'd4);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_done", 64'(done), 64'd0);
        check("midrun_rst_sum", 64'(sum), 64'd0);
        check("midrun_rst_cout", 64'(cout), 64'd0);
        check("midrun_rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (2 * W) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("midrun_no_done_after_abort", 64'(cnt), 64'd0);
        run_op("after_abort", 1'b0, 8'd77, 8'd66, 1'b1, W + 1, 1'b0, 1'b0);

        // A few random operations through the same path.
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), W + 1, 1'b0, 1'b0);
        end

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder
